// File: rtl/muldiv_unit_if.sv
// Handshake and operand bundle between the execute stage and the
// iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            Funct3;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Result;

    modport master (
        output start, Funct3, SrcA, SrcB,
        input  busy, done, Result
    );

    modport slave (
        input  start, Funct3, SrcA, SrcB,
        output busy, done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// when latched, a 32-step unsigned shift-add or restoring-division core
// runs, and the sign is restored as the result is captured on entry to DONE.
// Divide-by-zero and signed overflow are resolved at latch time with no
// iterations.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    logic [1:0]     state;
    logic [4:0]     count;
    logic [2:0]     op;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic           neg_res;
    logic           neg_rem;
    logic [2*W-1:0] acc;
    logic [W:0]     rem;
    logic [W-1:0]   quo;
    logic [W-1:0]   result;

    // Operand decode for the request currently on the bus.
    logic [2:0]   f3;
    logic         a_signed;
    logic         b_signed;
    logic         sign_a;
    logic         sign_b;
    logic [W-1:0] mag_a_in;
    logic [W-1:0] mag_b_in;
    logic         div_zero;
    logic         div_ovf;
    logic         special;
    logic [W-1:0] special_result;

    assign f3       = bus.Funct3;
    assign a_signed = f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
    assign b_signed = f3[2] ? ~f3[0] : ~f3[1];
    assign sign_a   = a_signed & bus.SrcA[W-1];
    assign sign_b   = b_signed & bus.SrcB[W-1];
    assign mag_a_in = sign_a ? -bus.SrcA : bus.SrcA;
    assign mag_b_in = sign_b ? -bus.SrcB : bus.SrcB;

    assign div_zero = (bus.SrcB == '0);
    assign div_ovf  = ~f3[0] & (bus.SrcA == MIN_NEG) & (bus.SrcB == ALL_ONES);
    assign special  = f3[2] & (div_zero | div_ovf);
    assign special_result = div_zero ? (f3[1] ? bus.SrcA : ALL_ONES)
                                     : (f3[1] ? '0 : MIN_NEG);

    // One shift-add step: low half of acc holds the remaining multiplier bits.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   mul_result;

    assign mul_sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign acc_next   = {mul_sum, acc[W-1:1]};
    assign prod_fixed = neg_res ? -acc_next : acc_next;
    assign mul_result = (op[1:0] == 2'b00) ? prod_fixed[W-1:0] : prod_fixed[2*W-1:W];

    // One restoring-division step: quo shifts dividend bits out and quotient bits in.
    logic [W:0]   shifted;
    logic [W+1:0] trial;
    logic         q_bit;
    logic [W:0]   rem_next;
    logic [W-1:0] quo_next;
    logic [W-1:0] quo_fixed;
    logic [W-1:0] rem_fixed;
    logic [W-1:0] div_result;

    assign shifted    = {rem[W-1:0], quo[W-1]};
    assign trial      = {rem, quo[W-1]} - {2'b00, mag_b};
    assign q_bit      = ~trial[W+1];
    assign rem_next   = q_bit ? trial[W:0] : shifted;
    assign quo_next   = {quo[W-2:0], q_bit};
    assign quo_fixed  = neg_res ? -quo_next : quo_next;
    assign rem_fixed  = neg_rem ? -rem_next[W-1:0] : rem_next[W-1:0];
    assign div_result = op[1] ? rem_fixed : quo_fixed;

    assign bus.busy   = (state == S_MUL) || (state == S_DIV);
    assign bus.done   = (state == S_DONE);
    assign bus.Result = result;

    // Sequencer and datapath registers: latch on start, iterate 32 steps, capture result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            op      <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            quo     <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op      <= f3;
                        mag_a   <= mag_a_in;
                        mag_b   <= mag_b_in;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        acc     <= {{W{1'b0}}, mag_b_in};
                        rem     <= '0;
                        quo     <= mag_a_in;
                        count   <= '0;
                        if (special) begin
                            state  <= S_DONE;
                            result <= special_result;
                        end else begin
                            state <= f3[2] ? S_DIV : S_MUL;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state  <= S_DONE;
                        result <= mul_result;
                    end
                end
                S_DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state  <= S_DONE;
                        result <= div_result;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: every M-extension operation, the
// divide special cases, start-while-busy, back-to-back and mid-op reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic [31:0] prev_result;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
        bus.start  = 1'b1;
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
    endtask

    // Issues one op (called right after a falling edge) and follows it to done.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected,
                          input int exp_cycle, input int inject_cycle, input bit check_hold);
        int done_cycle = 0;
        bit busy_ok = 1'b1;
        bit hold_ok = 1'b1;
        apply_stimulus(f3, a, b);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 40 && done_cycle == 0; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cycle = cyc;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
            end else begin
                if (bus.busy !== ((exp_cycle > 1) && (cyc < exp_cycle))) busy_ok = 1'b0;
                if (bus.Result !== prev_result) hold_ok = 1'b0;
            end
            if (cyc == inject_cycle) apply_stimulus(3'b000, 32'd3, 32'd3);
            else if (cyc == inject_cycle + 1) bus.start = 1'b0;
        end
        check_output({tag, " done_cycle"}, done_cycle, exp_cycle);
        check_output({tag, " result"}, bus.Result, expected);
        check_output({tag, " busy_pattern"}, {31'd0, busy_ok}, 32'd1);
        check_output({tag, " result_held"}, {31'd0, hold_ok}, 32'd1);
        prev_result = expected;
        if (check_hold) begin
            @(negedge clk);
            check_output({tag, " done_drops"}, {31'd0, bus.done}, 32'd0);
            check_output({tag, " result_after"}, bus.Result, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.Funct3 = 3'b000;
        bus.SrcA   = '0;
        bus.SrcB   = '0;
        prev_result = 32'd0;
        repeat (2) @(negedge clk);
        check_output("reset busy", {31'd0, bus.busy}, 32'd0);
        check_output("reset done", {31'd0, bus.done}, 32'd0);
        check_output("reset result", bus.Result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] multiply");
        run_op("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, 1'b1);
        run_op("MULH min*min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0, 1'b1);
        run_op("MULHU max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, 1'b1);
        run_op("MULHSU -1*max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, 1'b1);

        $display("[TB] divide");
        run_op("DIV -7/2",   3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0, 1'b1);
        run_op("REM -7/2",   3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0, 1'b1);
        run_op("DIVU 100/7", 3'b101, 32'd100,      32'd7, 32'd14,       33, 0, 1'b1);
        run_op("REMU 100/7", 3'b111, 32'd100,      32'd7, 32'd2,        33, 0, 1'b1);

        $display("[TB] special cases");
        run_op("DIV 5/0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 1'b1);
        run_op("REMU 5/0",     3'b111, 32'd5,        32'd0,        32'd5,        1, 0, 1'b1);
        run_op("DIV min/-1",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 1'b1);
        run_op("REM min/-1",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0, 1'b1);

        $display("[TB] start while busy, then back-to-back");
        run_op("DIVU inject",  3'b101, 32'd100,      32'd7, 32'd14,       33, 10, 1'b0);
        run_op("DIV b2b",      3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0,  1'b1);

        $display("[TB] reset mid-operation");
        apply_stimulus(3'b000, 32'd5, 32'd6);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (15) @(negedge clk);
        check_output("midop busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("abort busy", {31'd0, bus.busy}, 32'd0);
        check_output("abort done", {31'd0, bus.done}, 32'd0);
        check_output("abort result", bus.Result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_result = 32'd0;
        run_op("MUL 6*7 after reset", 3'b000, 32'd6, 32'd7, 32'd42, 33, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
